// File: rtl/mips_cpu_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, grant choice, lane mask.
package mips_cpu_mem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_I,
    ISSUE_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } gnt_t;

  localparam logic [BE_W-1:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mips_cpu_mem_arbiter_prio.sv
// Grant choice between fetch and data ports, with a saturating starvation counter
// that forces a fetch grant after STARVE_LIMIT consecutive data grants.
module mips_cpu_mem_arbiter_prio
  import mips_cpu_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic instr_req,
  input  logic data_req,
  input  logic take,
  output gnt_t gnt_c
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    gnt_c = GNT_D;
    if (instr_req && (!data_req || (starve_q == LIMIT))) gnt_c = GNT_I;
  end

  // Counter only moves on an actual grant; it counts data wins while fetch waits.
  always_comb begin
    starve_d = starve_q;
    if (take) begin
      if (gnt_c == GNT_I)      starve_d = '0;
      else if (!instr_req)     starve_d = '0;
      else if (starve_q != LIMIT) starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one Avalon-style memory between the fetch and data ports, one access at a time.
// Optional grant/conflict statistics counters are enabled with MEM_ARB_STATS_EN.
module mips_cpu_mem_arbiter
  import mips_cpu_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_read,
  input  logic [ADDR_W-1:0] instr_address,
  output logic [DATA_W-1:0] instr_readdata,
  output logic              instr_waitrequest,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [BE_W-1:0]   data_byteenable,
  input  logic [DATA_W-1:0] data_writedata,
  output logic [DATA_W-1:0] data_readdata,
  output logic              data_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_instr_grants,
  output logic [31:0]       stat_data_grants,
  output logic [31:0]       stat_conflicts
`endif
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic data_req_c;
  logic take_c;
  gnt_t gnt_c;

  assign data_req_c = data_read || data_write;
  assign take_c     = (state_q == IDLE) && (instr_read || data_req_c);

  mips_cpu_mem_arbiter_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk      (clk),
    .rst      (reset),
    .instr_req(instr_read),
    .data_req (data_req_c),
    .take     (take_c),
    .gnt_c    (gnt_c)
  );

  // Next-state and memory-command logic; the command is latched only at grant.
  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (take_c) begin
          if (gnt_c == GNT_I) begin
            mem_address_d = instr_address;
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
            mem_be_d      = BE_ALL;
            state_d       = ISSUE_I;
          end else begin
            mem_address_d = data_address;
            if (data_write) begin
              mem_read_d  = 1'b0;
              mem_write_d = 1'b1;
              mem_be_d    = data_byteenable;
              mem_wdata_d = data_writedata;
            end else begin
              mem_read_d  = 1'b1;
              mem_write_d = 1'b0;
              mem_be_d    = BE_ALL;
            end
            state_d = ISSUE_D;
          end
        end
      end
      ISSUE_I: begin
        if (!mem_waitrequest) begin
          mem_read_d    = 1'b0;
          instr_rdata_d = mem_readdata;
          state_d       = DONE_I;
        end
      end
      ISSUE_D: begin
        if (!mem_waitrequest) begin
          if (mem_read_q) data_rdata_d = mem_readdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = DONE_D;
        end
      end
      DONE_I:  state_d = IDLE;
      DONE_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign mem_address       = mem_address_q;
  assign mem_read          = mem_read_q;
  assign mem_write         = mem_write_q;
  assign mem_byteenable    = mem_be_q;
  assign mem_writedata     = mem_wdata_q;
  assign instr_readdata    = instr_rdata_q;
  assign data_readdata     = data_rdata_q;
  assign instr_waitrequest = instr_read && (state_q != DONE_I);
  assign data_waitrequest  = data_req_c && (state_q != DONE_D);

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_i_q, stat_i_d;
  logic [31:0] stat_d_q, stat_d_d;
  logic [31:0] stat_c_q, stat_c_d;

  // A conflict is an IDLE cycle with both ports requesting; counters wrap.
  always_comb begin
    stat_i_d = stat_i_q;
    stat_d_d = stat_d_q;
    stat_c_d = stat_c_q;
    if (take_c && (gnt_c == GNT_I)) stat_i_d = stat_i_q + 32'd1;
    if (take_c && (gnt_c == GNT_D)) stat_d_d = stat_d_q + 32'd1;
    if (take_c && instr_read && data_req_c) stat_c_d = stat_c_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
      stat_c_q <= '0;
    end else begin
      stat_i_q <= stat_i_d;
      stat_d_q <= stat_d_d;
      stat_c_q <= stat_c_d;
    end
  end

  assign stat_instr_grants = stat_i_q;
  assign stat_data_grants  = stat_d_q;
  assign stat_conflicts    = stat_c_q;
`endif

`ifndef SYNTHESIS
  a_no_read_and_write: assert property (@(posedge clk) disable iff (reset)
    !(data_read && data_write))
    else $error("data_read and data_write asserted together");
`endif

endmodule
